key_debounce: RTL

Front-end conditioner for a raw mechanical pushbutton in the calc datapath. It synchronises the asynchronous active-low key pin, rejects contact bounce with a stability counter, and drives a clean active-high level `key_level`. That level feeds the `A` input of the calc control FSM (`fsm`). The block also emits single-cycle press and release strobes and a long-press `key_hold` flag for downstream logic.

---
 rtl/key_debounce_pkg.sv | 16 +
 rtl/key_debounce_sync_2ff.sv | 24 ++
 rtl/key_debounce.sv | 133 +++++++++++++
 3 files changed

// File: rtl/key_debounce_pkg.sv
// Shared definitions for the pushbutton conditioner: FSM state encodings and
// default timing constants for a 50 MHz system clock.
package key_debounce_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'b00,
      PRESS_DB   = 2'b01,
      PRESSED    = 2'b10,
      RELEASE_DB = 2'b11
   } state_t;

   // 20 ms debounce window and 1 s long-press threshold at 50 MHz
   localparam int DEFAULT_DB_CYCLES   = 1_000_000;
   localparam int DEFAULT_HOLD_CYCLES = 50_000_000;

endpackage

// File: rtl/key_debounce_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input; the reset value is a
// parameter so the same cell serves active-low and active-high pins alike.
module sync_2ff #(
   parameter logic RESET_VALUE = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= RESET_VALUE;
         q    <= RESET_VALUE;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/key_debounce.sv
// Debounces an active-low mechanical key into a clean active-high level with
// press/release strobes and a long-press flag; all outputs are registered.
import key_debounce_pkg::*;

module key_debounce #(
   parameter int DB_CYCLES   = DEFAULT_DB_CYCLES,
   parameter int HOLD_CYCLES = DEFAULT_HOLD_CYCLES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_in,
   output logic key_level,
   output logic key_press,
   output logic key_release,
   output logic key_hold
);

   localparam int DB_W   = $clog2(DB_CYCLES + 1);
   localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

   localparam logic [DB_W-1:0]   DB_ONE   = DB_W'(1);
   localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DB_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);

   logic key_s;

   state_t            state, state_next;
   logic [DB_W-1:0]   db_cnt, db_cnt_next;
   logic [HOLD_W-1:0] hold_cnt, hold_cnt_next, hold_inc;
   logic              key_level_next, key_press_next;
   logic              key_release_next, key_hold_next;

   sync_2ff #(
      .RESET_VALUE (1'b1)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (key_in),
      .q     (key_s)
   );

   assign hold_inc = (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + HOLD_W'(1);

   // The last debounce sample is the one that arrives while the counter
   // already holds DB_CYCLES-1, so the decision registers on that same edge.
   always_comb begin
      state_next       = state;
      db_cnt_next      = db_cnt;
      hold_cnt_next    = hold_cnt;
      key_level_next   = key_level;
      key_press_next   = 1'b0;
      key_release_next = 1'b0;
      key_hold_next    = key_hold;

      case (state)
         IDLE: begin
            if (!key_s) begin
               state_next  = PRESS_DB;
               db_cnt_next = DB_ONE;
            end else begin
               db_cnt_next = '0;
            end
         end

         PRESS_DB: begin
            if (key_s) begin
               state_next  = IDLE;
               db_cnt_next = '0;
            end else if (db_cnt == DB_LAST) begin
               state_next     = PRESSED;
               db_cnt_next    = '0;
               hold_cnt_next  = '0;
               key_level_next = 1'b1;
               key_press_next = 1'b1;
            end else begin
               db_cnt_next = db_cnt + DB_W'(1);
            end
         end

         PRESSED: begin
            hold_cnt_next = hold_inc;
            if (hold_inc == HOLD_MAX) key_hold_next = 1'b1;
            if (key_s) begin
               state_next  = RELEASE_DB;
               db_cnt_next = DB_ONE;
            end
         end

         RELEASE_DB: begin
            hold_cnt_next = hold_inc;
            if (hold_inc == HOLD_MAX) key_hold_next = 1'b1;
            if (!key_s) begin
               state_next  = PRESSED;
               db_cnt_next = '0;
            end else if (db_cnt == DB_LAST) begin
               state_next       = IDLE;
               db_cnt_next      = '0;
               key_level_next   = 1'b0;
               key_release_next = 1'b1;
               key_hold_next    = 1'b0;
            end else begin
               db_cnt_next = db_cnt + DB_W'(1);
            end
         end

         default: begin
            state_next  = IDLE;
            db_cnt_next = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         db_cnt      <= '0;
         hold_cnt    <= '0;
         key_level   <= 1'b0;
         key_press   <= 1'b0;
         key_release <= 1'b0;
         key_hold    <= 1'b0;
      end else begin
         state       <= state_next;
         db_cnt      <= db_cnt_next;
         hold_cnt    <= hold_cnt_next;
         key_level   <= key_level_next;
         key_press   <= key_press_next;
         key_release <= key_release_next;
         key_hold    <= key_hold_next;
      end
   end

endmodule
